card_match_ctrl: RTL and testbench

Game controller for the 6x6 card-matching game. Owns the player cursor, the two-pick turn sequence, card-value lookup against the deck ROM, match detection, the mismatch reveal timer and end-of-game detection. Sits directly upstream of the LED grid driver: `cursor` feeds its selected-card input, and `card1`/`card2` feed its found-pair inputs.

---
 rtl/card_match_ctrl.sv | 153 +++++++++++++++
 tb/tb_card_match_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_match_ctrl.sv
// card_match_ctrl: game controller for the 6x6 card-matching game.
// Tracks the cursor and the two-pick turn sequence. Each pick is looked up in
// the deck ROM, and the controller detects matches, holds a mismatched pair
// face-up for a timed reveal, and detects the end of the game.
module card_match_ctrl #(
    parameter int REVEAL_CYCLES = 50_000_000,
    parameter int NUM_PAIRS     = 18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    output logic [5:0]  card_addr,
    input  logic [4:0]  card_val,
    output logic [5:0]  cursor,
    output logic [5:0]  first_loc,
    output logic        first_valid,
    output logic [5:0]  second_loc,
    output logic        reveal,
    output logic [5:0]  card1,
    output logic [5:0]  card2,
    output logic        match_stb,
    output logic [35:0] found,
    output logic [4:0]  pairs_left,
    output logic        game_done
);

    typedef enum logic [2:0] {
        PICK1,
        LATCH1,
        PICK2,
        LATCH2,
        REVEAL,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  val1;
    logic [25:0] reveal_cnt;
    logic        any_move;
    logic        sel_ok;
    logic [2:0]  col;
    logic [5:0]  cursor_next;

    // The ROM is addressed straight from the cursor, so it samples the card
    // under the cursor on the same edge that accepts a select.
    assign card_addr = cursor;
    assign any_move  = btn_up | btn_down | btn_left | btn_right;
    assign sel_ok    = btn_sel & ~any_move;

    // Next cursor location: one move per cycle, priority up > down > left > right, wrapping within the axis.
    always_comb begin
        col         = 3'(cursor % 6'd6);
        cursor_next = cursor;
        if (btn_up)
            cursor_next = (cursor < 6'd6) ? cursor + 6'd30 : cursor - 6'd6;
        else if (btn_down)
            cursor_next = (cursor >= 6'd30) ? cursor - 6'd30 : cursor + 6'd6;
        else if (btn_left)
            cursor_next = (col == 3'd0) ? cursor + 6'd5 : cursor - 6'd1;
        else if (btn_right)
            cursor_next = (col == 3'd5) ? cursor - 6'd5 : cursor + 6'd1;
    end

    // Turn sequencer: cursor, the two picks, match bookkeeping, reveal timer and restart.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= PICK1;
            cursor      <= 6'd0;
            first_loc   <= 6'd0;
            second_loc  <= 6'd0;
            first_valid <= 1'b0;
            reveal      <= 1'b0;
            card1       <= 6'd63;
            card2       <= 6'd63;
            match_stb   <= 1'b0;
            found       <= 36'd0;
            pairs_left  <= 5'(NUM_PAIRS);
            game_done   <= 1'b0;
            val1        <= 5'd0;
            reveal_cnt  <= 26'd0;
        end else begin
            match_stb <= 1'b0;
            if (state != DONE)
                cursor <= cursor_next;

            case (state)
                PICK1: begin
                    if (sel_ok && !found[cursor]) begin
                        first_loc <= cursor;
                        state     <= LATCH1;
                    end
                end
                LATCH1: begin
                    val1        <= card_val;
                    first_valid <= 1'b1;
                    state       <= PICK2;
                end
                PICK2: begin
                    if (sel_ok && !found[cursor] && (cursor != first_loc)) begin
                        second_loc <= cursor;
                        state      <= LATCH2;
                    end
                end
                LATCH2: begin
                    if (card_val == val1) begin
                        found       <= found | (36'd1 << first_loc) | (36'd1 << second_loc);
                        card1       <= first_loc;
                        card2       <= second_loc;
                        match_stb   <= 1'b1;
                        pairs_left  <= pairs_left - 5'd1;
                        first_valid <= 1'b0;
                        if (pairs_left == 5'd1) begin
                            game_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= PICK1;
                        end
                    end else begin
                        reveal     <= 1'b1;
                        reveal_cnt <= 26'(REVEAL_CYCLES - 1);
                        state      <= REVEAL;
                    end
                end
                REVEAL: begin
                    if (reveal_cnt == 26'd0) begin
                        reveal      <= 1'b0;
                        first_valid <= 1'b0;
                        state       <= PICK1;
                    end else begin
                        reveal_cnt <= reveal_cnt - 26'd1;
                    end
                end
                DONE: begin
                    if (sel_ok) begin
                        found      <= 36'd0;
                        pairs_left <= 5'(NUM_PAIRS);
                        card1      <= 6'd63;
                        card2      <= 6'd63;
                        game_done  <= 1'b0;
                        cursor     <= 6'd0;
                        state      <= PICK1;
                    end
                end
                default: state <= PICK1;
            endcase
        end
    end

endmodule

// File: tb/tb_card_match_ctrl.sv
// tb_card_match_ctrl: drives card_match_ctrl through cursor moves, matches,
// mismatches, ignored selects, a full game and a reset during a reveal.
// Expected values come from a board-level model: the cursor is kept as a
// row/col pair and the board as a set of found locations.
module tb_card_match_ctrl;

    localparam int RC = 5;
    localparam int NP = 18;

    logic        clock = 1'b0;
    logic        reset;
    logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [5:0]  card_addr;
    logic [4:0]  card_val;
    logic [5:0]  cursor, first_loc, second_loc, card1, card2;
    logic        first_valid, reveal, match_stb, game_done;
    logic [35:0] found;
    logic [4:0]  pairs_left;

    logic [4:0]  deck [36];

    int tests = 0;
    int fails = 0;

    int          mrow, mcol, mphase, mfirst, msecond, mpairs, mcard1, mcard2;
    bit          mdone;
    logic [35:0] mfound;

    card_match_ctrl #(.REVEAL_CYCLES(RC), .NUM_PAIRS(NP)) dut (
        .clock(clock), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .card_addr(card_addr), .card_val(card_val),
        .cursor(cursor), .first_loc(first_loc), .first_valid(first_valid),
        .second_loc(second_loc), .reveal(reveal),
        .card1(card1), .card2(card2), .match_stb(match_stb),
        .found(found), .pairs_left(pairs_left), .game_done(game_done)
    );

    always #5 clock = ~clock;

    // Synchronous deck ROM with one cycle of latency.
    always @(posedge clock) card_val <= deck[card_addr];

    function automatic int curLoc();
        return mrow * 6 + mcol;
    endfunction

    function automatic int partnerOf(input int i);
        for (int j = 0; j < 36; j++)
            if (j != i && deck[j] == deck[i]) return j;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit u, input bit d, input bit l, input bit r, input bit s);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
        tick();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;
    endtask

    task automatic modelReset();
        mrow = 0; mcol = 0; mphase = 0; mfirst = 0; msecond = 0;
        mpairs = NP; mcard1 = 63; mcard2 = 63; mdone = 0; mfound = '0;
    endtask

    task automatic checkResetValues(input string p);
        checkOutput({p, "_cursor"},      cursor,      0);
        checkOutput({p, "_card_addr"},   card_addr,   0);
        checkOutput({p, "_first_loc"},   first_loc,   0);
        checkOutput({p, "_second_loc"},  second_loc,  0);
        checkOutput({p, "_first_valid"}, first_valid, 0);
        checkOutput({p, "_reveal"},      reveal,      0);
        checkOutput({p, "_card1"},       card1,       63);
        checkOutput({p, "_card2"},       card2,       63);
        checkOutput({p, "_match_stb"},   match_stb,   0);
        checkOutput({p, "_found"},       found,       0);
        checkOutput({p, "_pairs_left"},  pairs_left,  NP);
        checkOutput({p, "_game_done"},   game_done,   0);
    endtask

    // dir: 0 up, 1 down, 2 left, 3 right
    task automatic moveModel(input int dir);
        if (!mdone) begin
            case (dir)
                0: mrow = (mrow + 5) % 6;
                1: mrow = (mrow + 1) % 6;
                2: mcol = (mcol + 5) % 6;
                default: mcol = (mcol + 1) % 6;
            endcase
        end
    endtask

    task automatic pressMove(input int dir);
        applyStimulus(dir == 0, dir == 1, dir == 2, dir == 3, 1'b0);
        moveModel(dir);
        checkOutput("cursor", cursor, curLoc());
        checkOutput("card_addr", card_addr, curLoc());
    endtask

    task automatic moveTo(input int target);
        int d;
        d = (target / 6 - mrow + 6) % 6;
        if (d <= 3) repeat (d) pressMove(1);
        else        repeat (6 - d) pressMove(0);
        d = (target % 6 - mcol + 6) % 6;
        if (d <= 3) repeat (d) pressMove(3);
        else        repeat (6 - d) pressMove(2);
    endtask

    task automatic pressSel();
        int cur;
        cur = curLoc();
        applyStimulus(0, 0, 0, 0, 1);
        if (mdone) begin
            modelReset();
            checkOutput("restart_found",     found,      0);
            checkOutput("restart_pairs",     pairs_left, NP);
            checkOutput("restart_card1",     card1,      63);
            checkOutput("restart_card2",     card2,      63);
            checkOutput("restart_game_done", game_done,  0);
            checkOutput("restart_cursor",    cursor,     0);
        end else if (mphase == 0 && !mfound[cur]) begin
            mfirst = cur;
            checkOutput("first_loc", first_loc, cur);
            tick();
            checkOutput("first_valid_set", first_valid, 1);
            mphase = 1;
        end else if (mphase == 1 && !mfound[cur] && cur != mfirst) begin
            msecond = cur;
            checkOutput("second_loc", second_loc, cur);
            checkOutput("match_stb_early", match_stb, 0);
            tick();
            mphase = 0;
            if (deck[mfirst] == deck[cur]) begin
                mfound[mfirst] = 1'b1;
                mfound[cur]    = 1'b1;
                mcard1 = mfirst;
                mcard2 = cur;
                mpairs--;
                mdone = (mpairs == 0);
                checkOutput("match_stb", match_stb, 1);
                checkOutput("card1", card1, mcard1);
                checkOutput("card2", card2, mcard2);
                checkOutput("found_match", found, mfound);
                checkOutput("pairs_left", pairs_left, mpairs);
                checkOutput("first_valid_match", first_valid, 0);
                checkOutput("game_done", game_done, mdone);
                tick();
                checkOutput("match_stb_pulse", match_stb, 0);
            end else begin
                for (int k = 0; k < RC; k++) begin
                    checkOutput("reveal_high", reveal, 1);
                    checkOutput("reveal_first_valid", first_valid, 1);
                    tick();
                end
                checkOutput("reveal_low", reveal, 0);
                checkOutput("first_valid_after_reveal", first_valid, 0);
                checkOutput("found_mismatch", found, mfound);
                checkOutput("match_stb_mismatch", match_stb, 0);
            end
        end else begin
            tick();
            checkOutput("ignored_first_valid", first_valid, mphase);
            checkOutput("ignored_first_loc", first_loc, mfirst);
            checkOutput("ignored_reveal", reveal, 0);
            checkOutput("ignored_match_stb", match_stb, 0);
            checkOutput("ignored_found", found, mfound);
        end
    endtask

    task automatic pressSelWithMove(input int dir);
        applyStimulus(dir == 0, dir == 1, dir == 2, dir == 3, 1'b1);
        moveModel(dir);
        checkOutput("selmove_cursor", cursor, curLoc());
        tick();
        checkOutput("selmove_second_loc", second_loc, msecond);
        checkOutput("selmove_first_valid", first_valid, mphase);
        checkOutput("selmove_reveal", reveal, 0);
        checkOutput("selmove_match_stb", match_stb, 0);
    endtask

    task automatic pickPair(input int a, input int b);
        moveTo(a);
        pressSel();
        moveTo(b);
        pressSel();
    endtask

    initial begin
        int q[$];
        int i, j, k, start, tmp;

        reset = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_sel = 0;

        // Deck: locations 0..3 fixed, remaining values shuffled over 4..35.
        for (int v = 0; v < 18; v++) begin
            int c;
            c = (v == 3) ? 0 : ((v == 4 || v == 9) ? 1 : 2);
            repeat (c) q.push_back(v);
        end
        for (int n = q.size() - 1; n > 0; n--) begin
            int m;
            m = int'($urandom_range(0, n));
            tmp = q[n]; q[n] = q[m]; q[m] = tmp;
        end
        deck[0] = 5'd3; deck[1] = 5'd3; deck[2] = 5'd4; deck[3] = 5'd9;
        for (int n = 0; n < 32; n++) deck[n + 4] = 5'(q[n]);
        modelReset();

        repeat (2) @(posedge clock);
        #1;
        checkResetValues("rst");
        reset = 1'b0;
        tick();
        checkResetValues("post_rst");

        // Cursor moves and wrap-around.
        pressMove(3);
        pressMove(1);
        pressMove(2);
        moveTo(5);
        pressMove(3);
        pressMove(0);

        // First match at 0/1, then a mismatch at 2/3.
        pickPair(0, 1);
        pickPair(2, 3);

        // Ignored selects: found location, same location twice, sel with a move.
        moveTo(0);
        pressSel();
        moveTo(2);
        pressSel();
        pressSel();
        moveTo(5);
        pressSelWithMove(3);
        moveTo(partnerOf(2));
        pressSel();

        // Clear the board, with occasional random mismatches in between.
        while (mpairs > 0) begin
            start = int'($urandom_range(0, 35));
            i = 0;
            for (int off = 0; off < 36; off++) begin
                i = (start + off) % 36;
                if (!mfound[i]) break;
            end
            j = partnerOf(i);
            if (mpairs > 1 && $urandom_range(0, 3) == 0) begin
                start = int'($urandom_range(0, 35));
                k = 0;
                for (int off = 0; off < 36; off++) begin
                    k = (start + off) % 36;
                    if (!mfound[k] && deck[k] != deck[i]) break;
                end
                pickPair(i, k);
            end
            pickPair(i, j);
        end
        checkOutput("done_game_done", game_done, 1);
        checkOutput("done_pairs_left", pairs_left, 0);
        pressMove(3);
        pressMove(1);
        pressSel();

        // Reset in the middle of a reveal.
        pickPair(0, 1);
        moveTo(2);
        pressSel();
        moveTo(3);
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        checkOutput("reveal_before_reset", reveal, 1);
        tick();
        reset = 1'b1;
        #1;
        modelReset();
        checkResetValues("mid_reveal_rst");
        @(negedge clock);
        reset = 1'b0;
        tick();
        checkResetValues("after_mid_reveal_rst");
        pressMove(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
